// File: rtl/shared_reg_arbiter.sv
// Four-requester round-robin arbiter guarding one shared register.
// All state advances on the falling edge of clk.
module shared_reg_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int WIDTH    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [3:0]         wr,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         gnt,
  output logic [1:0]         owner,
  output logic               busy,
  output logic [WIDTH-1:0]   rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t           r_state = IDLE;
  logic [3:0]       r_gnt   = '0;
  logic [1:0]       r_owner = '0;
  logic [1:0]       r_ptr   = '0;
  logic [3:0]       r_hold  = '0;
  logic [WIDTH-1:0] r_rdata = '0;

  state_t           w_state;
  logic [3:0]       w_gnt;
  logic [1:0]       w_owner;
  logic [1:0]       w_ptr;
  logic [3:0]       w_hold;
  logic [WIDTH-1:0] w_rdata;
  logic [1:0]       w_idx;
  logic [1:0]       w_sel;
  logic             w_found;

  // Walk downwards so the lowest offset from ptr is assigned last and wins.
  always_comb begin
    w_idx   = '0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin
    w_state = r_state;
    w_gnt   = r_gnt;
    w_owner = r_owner;
    w_ptr   = r_ptr;
    w_hold  = r_hold;
    w_rdata = r_rdata;
    unique case (r_state)
      IDLE, RELEASE: begin
        w_state = IDLE;
        w_gnt   = '0;
        w_owner = '0;
        // Requests seen while releasing are arbitrated on the closing edge.
        if (w_found) begin
          w_state = GRANT;
          w_gnt   = 4'b0001 << w_sel;
          w_owner = w_sel;
          w_hold  = '0;
        end
      end
      GRANT: begin
        if (!req[r_owner]) begin
          w_state = RELEASE;
          w_gnt   = '0;
          w_owner = '0;
          w_ptr   = r_owner + 2'd1;
        end else begin
          if (wr[r_owner])
            w_rdata = wdata[r_owner*WIDTH +: WIDTH];
          if (r_hold == HOLD_LAST) begin
            w_state = RELEASE;
            w_gnt   = '0;
            w_owner = '0;
            w_ptr   = r_owner + 2'd1;
          end else begin
            w_hold = r_hold + 4'd1;
          end
        end
      end
      default: begin
        w_state = IDLE;
        w_gnt   = '0;
        w_owner = '0;
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state;
      r_gnt   <= w_gnt;
      r_owner <= w_owner;
      r_ptr   <= w_ptr;
      r_hold  <= w_hold;
      r_rdata <= w_rdata;
    end
  end

  assign gnt   = r_gnt;
  assign owner = r_owner;
  assign busy  = (r_state != IDLE);
  assign rdata = r_rdata;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter.
// Inputs change and outputs are sampled at posedge, away from the active negedge.
module tb_shared_reg_arbiter;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [3:0]     req = '0;
  logic [3:0]     wr = '0;
  logic [4*W-1:0] wdata = '0;
  logic [3:0]     gnt;
  logic [1:0]     owner;
  logic           busy;
  logic [W-1:0]   rdata;

  int n_chk = 0;
  int n_err = 0;

  shared_reg_arbiter #(.MAX_HOLD(4), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .wr    (wr),
    .wdata (wdata),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .rdata (rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic set_wd(input int i, input logic [W-1:0] v);
    wdata = '0;
    wdata[i*W +: W] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    wr = '0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    chk("pu_gnt", 32'(gnt), 32'h0);
    chk("pu_owner", 32'(owner), 32'h0);
    chk("pu_busy", 32'(busy), 32'h0);
    chk("pu_rdata", 32'(rdata), 32'h0);

    do_reset();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);

    // single requester write
    req = 4'b0001; wr = 4'b0001; set_wd(0, 8'hA5);
    step();
    chk("w1_gnt", 32'(gnt), 32'h1);
    chk("w1_busy", 32'(busy), 32'h1);
    chk("w1_rdata_e1", 32'(rdata), 32'h0);
    step();
    chk("w1_rdata_e2", 32'(rdata), 32'hA5);
    chk("w1_gnt_e2", 32'(gnt), 32'h1);
    req = '0; wr = '0;
    step();
    chk("w1_rel_gnt", 32'(gnt), 32'h0);
    chk("w1_rel_busy", 32'(busy), 32'h1);
    step();
    chk("w1_idle_busy", 32'(busy), 32'h0);
    chk("w1_idle_rdata", 32'(rdata), 32'hA5);

    // full round-robin rotation with MAX_HOLD expiry
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk($sformatf("rr%0d_gnt%0d", g, c), 32'(gnt), 32'(4'b0001 << (g % 4)));
        chk($sformatf("rr%0d_own%0d", g, c), 32'(owner), 32'(g % 4));
      end
      step();
      chk($sformatf("rr%0d_rel_gnt", g), 32'(gnt), 32'h0);
      chk($sformatf("rr%0d_rel_busy", g), 32'(busy), 32'h1);
    end
    req = '0;
    step();
    chk("rr_idle_busy", 32'(busy), 32'h0);

    // write on MAX_HOLD exit edge is kept
    do_reset();
    req = 4'b0001;
    step();
    step();
    step();
    step();
    chk("mh_pre_gnt", 32'(gnt), 32'h1);
    wr = 4'b0001; set_wd(0, 8'h77);
    step();
    chk("mh_rel_gnt", 32'(gnt), 32'h0);
    chk("mh_rdata", 32'(rdata), 32'h77);
    req = '0; wr = '0;
    step();

    // drop with write: discarded, ptr advances to 3
    do_reset();
    req = 4'b0100;
    step();
    chk("dr_gnt", 32'(gnt), 32'h4);
    chk("dr_owner", 32'(owner), 32'h2);
    wr = 4'b0100; set_wd(2, 8'h11);
    step();
    chk("dr_rdata_w", 32'(rdata), 32'h11);
    req = '0; wr = 4'b0100; set_wd(2, 8'h3C);
    step();
    chk("dr_rel_gnt", 32'(gnt), 32'h0);
    chk("dr_rel_busy", 32'(busy), 32'h1);
    chk("dr_rdata", 32'(rdata), 32'h11);
    req = 4'b1111; wr = '0;
    step();
    chk("dr_ptr_gnt", 32'(gnt), 32'h8);
    chk("dr_ptr_owner", 32'(owner), 32'h3);

    // non-owner write ignored
    do_reset();
    req = 4'b0010;
    step();
    chk("no_gnt", 32'(gnt), 32'h2);
    req = 4'b1010; wr = 4'b1000; set_wd(3, 8'hFF);
    step();
    chk("no_rdata", 32'(rdata), 32'h0);
    chk("no_gnt2", 32'(gnt), 32'h2);

    // reset during GRANT
    do_reset();
    req = 4'b1000;
    step();
    chk("rg_gnt", 32'(gnt), 32'h8);
    wr = 4'b1000; set_wd(3, 8'h55);
    step();
    chk("rg_rdata", 32'(rdata), 32'h55);
    reset = 1'b1;
    step();
    chk("rg_r_gnt", 32'(gnt), 32'h0);
    chk("rg_r_busy", 32'(busy), 32'h0);
    chk("rg_r_rdata", 32'(rdata), 32'h0);
    chk("rg_r_owner", 32'(owner), 32'h0);
    reset = 1'b0; req = 4'b1001; wr = '0;
    step();
    chk("rg_next_gnt", 32'(gnt), 32'h1);
    chk("rg_next_owner", 32'(owner), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
    $finish;
  end

endmodule
